// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU arithmetic path.
//   op_e    : ALU operation encodings carried on op_code
//   state_e : multi-precision sequencer control states
//   NIBBLE_W: width of the shared adder datapath
package cpu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_adder4.sv
// 4-bit ripple-carry adder, the shared arithmetic datapath of the CPU.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : nibble sum
//   cout : carry out of bit 3
module full_adder4
  import cpu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c[0] = cin;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-precision add/subtract controller. Streams W = 4*NIBBLES-bit operands
// through one shared full_adder4, LSB nibble first, one nibble per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : request handshake (ready only in IDLE)
//   op_a, op_b           : W-bit operands, sampled at accept only
//   op_code, op_cin      : ADD/ADC/SUB/SBB and carry input (SBB: 1 = no borrow)
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   result, flag_c/v/z   : sum/difference and carry, overflow, zero flags
//   busy                 : high in RUN or DONE
module nibble_add_sequencer
  import cpu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    op_a,
  input  logic [4*NIBBLES-1:0]    op_b,
  input  logic [1:0]              op_code,
  input  logic                    op_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    result,
  output logic                    flag_c,
  output logic                    flag_v,
  output logic                    flag_z,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  logic               z_q, z_d;

  logic [NIBBLE_W-1:0] fa_a, fa_b, fa_sum;
  logic                fa_cout;

  full_adder4 u_adder (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // The adder is always fed from the current nibble; its output only matters in RUN.
  always_comb begin
    fa_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    fa_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = op_a;
          idx_d = '0;
          case (op_e'(op_code))
            OP_ADD:  begin b_d =  op_b; carry_d = 1'b0;   end
            OP_ADC:  begin b_d =  op_b; carry_d = op_cin; end
            OP_SUB:  begin b_d = ~op_b; carry_d = 1'b1;   end
            default: begin b_d = ~op_b; carry_d = op_cin; end
          endcase
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[NIBBLE_W*idx_q +: NIBBLE_W] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          c_d = fa_cout;
          v_d = (a_q[W-1] == b_q[W-1]) & (fa_sum[NIBBLE_W-1] != a_q[W-1]);
          // Zero test must include the nibble being written this edge.
          z_d = ({fa_sum, result_q[W-NIBBLE_W-1:0]} == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    result    = result_q;
    flag_c    = c_q;
    flag_v    = v_q;
    flag_z    = z_q;
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   op_code;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_c, flag_v, flag_z;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_r;
  logic         exp_c, exp_v, exp_z;

  nibble_add_sequencer #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .op_cin    (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic, W+1 bits wide to capture the carry.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic cin);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    bb   = op[1] ? ~b : b;
    ci   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    exp_r = full[W-1:0];
    exp_c = full[W];
    exp_v = (a[W-1] == bb[W-1]) && (exp_r[W-1] != a[W-1]);
    exp_z = (exp_r == '0);
  endtask

  task automatic scramble_inputs();
    op_a    = W'($urandom);
    op_b    = W'($urandom);
    op_code = 2'($urandom);
    op_cin  = 1'($urandom);
  endtask

  // Presents a request at a negedge; returns after the accept edge (+1).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    op_a = a; op_b = b; op_code = op; op_cin = cin; in_valid = 1'b1;
    model(a, b, op, cin);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, NIB);
    chk("result", result, exp_r);
    chk("flag_c", flag_c, exp_c);
    chk("flag_v", flag_v, exp_v);
    chk("flag_z", flag_z, exp_z);
  endtask

  task automatic stall(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_result", {result, flag_c, flag_v, flag_z}, {exp_r, exp_c, exp_v, exp_z});
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
    chk("release_busy", busy, 0);
    chk("retain_result", result, exp_r);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic cin, input int st);
    start_op(a, b, op, cin);
    wait_done();
    stall(st);
    release_out();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_code = '0; op_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_c, flag_v, flag_z}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Directed boundary cases.
    do_op(16'h1234, 16'h0FFF, 2'b00, 1'b0, 0);
    chk("add_dir", result, 16'h2233);
    do_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 1);
    chk("wrap_dir", {result, flag_c, flag_z, flag_v}, {16'h0000, 3'b110});
    do_op(16'h8000, 16'h0001, 2'b10, 1'b0, 0);
    chk("subv_dir", {result, flag_c, flag_v, flag_z}, {16'h7FFF, 3'b110});
    do_op(16'h00FF, 16'h0000, 2'b01, 1'b1, 0);
    chk("adc_dir", {result, flag_c}, {16'h0100, 1'b0});
    do_op(16'h0000, 16'h0000, 2'b11, 1'b0, 0);
    chk("sbb_dir", {result, flag_c}, {16'hFFFF, 1'b0});

    // Backpressure with a second request pending during DONE.
    start_op(16'h4321, 16'h1111, 2'b10, 1'b0);
    wait_done();
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h00F1; op_code = 2'b00; op_cin = 1'b0; in_valid = 1'b1;
    stall(5);
    chk("bp_result", result, 16'h3210);
    release_out();
    @(posedge clk); #1;
    chk("bp_accept", busy, 1);
    in_valid = 1'b0;
    model(16'h0F0F, 16'h00F1, 2'b00, 1'b0);
    scramble_inputs();
    wait_done();
    release_out();

    // Asynchronous reset at idx == 2.
    start_op(16'h7777, 16'h1111, 2'b00, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {flag_c, flag_v, flag_z}, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_valid_after_rst", seen, 0);
    do_op(16'h1357, 16'h2468, 2'b00, 1'b0, 0);
    chk("post_rst_add", result, 16'h37BF);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Multi-precision add/subtract controller for the 4-bit CPU.
- Streams W = 4*NIBBLES-bit operands through a single shared 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Holds the inter-nibble carry in a register and returns result plus C/V/Z flags.
- Sits between the instruction decoder/ALU front-end and the 4-bit adder datapath; valid/ready on both sides.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (W = 4*NIBBLES, legal range 2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept a request (high only in IDLE).
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_code  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- op_cin  in  1  carry flag input for ADC/SBB (for SBB, 1 = no borrow).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- flag_c  out  1  carry out of MSB nibble (for subtract, 1 = no borrow).
- flag_v  out  1  signed overflow.
- flag_z  out  1  result == 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous, active-low. While rst_n = 0:
  - State = IDLE; carry reg, nibble index, operand regs and result = 0.
  - flag_c, flag_v, flag_z, out_valid and busy = 0; in_ready = 1 after reset release.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a = op_a.
  - b = op_b for ADD/ADC; b = ~op_b for SUB/SBB.
  - Carry reg = 0 (ADD), 1 (SUB), op_cin (ADC/SBB).
  - idx = 0 → RUN.
- State RUN (exactly NIBBLES cycles):
  - Adder inputs: a[4*idx+:4], b[4*idx+:4], cin = carry reg.
  - Each edge: result[4*idx+:4] <= sum; carry reg <= cout; idx <= idx+1.
  - On the edge with idx == NIBBLES-1, additionally:
    - flag_c <= cout.
    - flag_v <= (a_msb == b_msb) & (sum_msb != a_msb), where b_msb is the post-inversion b.
    - flag_z <= (completed result == 0), using the final nibble sum, not the stale register.
    - → DONE.
- State DONE:
  - out_valid = 1; result and flags held stable.
  - On out_ready → IDLE; out_valid drops on that edge.
- Latency: request accepted at edge k → out_valid high after edge k+NIBBLES. Throughput is one op per NIBBLES+2 cycles minimum (IDLE cycle re-entered before the next accept). No overlap of requests.
- in_valid while busy: ignored (in_ready = 0); the requester must hold its request.
- out_ready held low: DONE persists indefinitely; outputs unchanged.
- result/flags outside DONE:
  - Retain the last completed values.
  - Partial updates during RUN are permitted on result only.
  - The consumer must sample only on out_valid.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE, operation discarded, no out_valid pulse.
- op_code and operands are sampled only at accept; later changes have no effect.

Decomposition:
- Shared package (cpu_pkg):
  - op_code encodings ADD/ADC/SUB/SBB.
  - State enum IDLE/RUN/DONE.
  - NIBBLE_W = 4.
- Sub-module: the existing full_adder4, instantiated once as the shared datapath. The sequencer adds no other sub-modules.

Test Plan:
- ADD: a=0x1234, b=0x0FFF → result 0x2233, C=0, V=0, Z=0. out_valid exactly 4 cycles after the accept edge.
- ADD wrap: a=0xFFFF, b=0x0001 → result 0x0000, C=1, Z=1, V=0.
- SUB overflow: a=0x8000, b=0x0001 → result 0x7FFF, C=1, V=1, Z=0.
- ADC chain: a=0x00FF, b=0x0000, op_cin=1 → 0x0100, C=0. SBB: a=0x0000, b=0x0000, op_cin=0 → 0xFFFF, C=0.
- Backpressure: out_ready low for 5 cycles in DONE.
  - Result and flags stay stable; in_ready stays 0; second in_valid is not accepted.
  - Release out_ready → next request is accepted one cycle later.
- Reset: assert rst_n=0 asynchronously mid-RUN (idx=2).
  - All outputs are 0 immediately; no out_valid follows.
  - A fresh ADD after release completes correctly.
